line_window_sequencer: RTL
==========================

// Module: line_window_sequencer
// PURPOSE
//   Frame-level sequencer for the preparation stage. Drives a chain of KSIZE-1 line buffers
//   (buffer 0 fed with raw pixels, buffer k fed by the output of buffer k-1).
//   Tracks the row/column of every accepted pixel and gates the buffer write/read enables.
//   Flags when a complete KSIZE x KSIZE window is available to the downstream filter.
// PARAMETERS
//   WIDTH   17  pixels per line; equals DEPTH of every line buffer
//   HEIGHT  17  lines per frame
//   KSIZE   3   window size; instantiates KSIZE-1 buffer enables; legal range 2..min(WIDTH,HEIGHT)
//   CNT_W   10  row/column counter width; must satisfy 2**CNT_W > max(WIDTH,HEIGHT)
// PORTS
//   clk             in   1        single clock, rising edge
//   rst             in   1        asynchronous, active-low reset
//   start_i         in   1        frame start pulse; honoured only in IDLE
//   done_i          in   1        pixel valid strobe from upstream, one pixel per high cycle
//   lb_wr_en        out  KSIZE-1  per-buffer write enable (combinational)
//   lb_rd_en        out  KSIZE-1  per-buffer read enable (combinational)
//   col_o           out  CNT_W    column of the next pixel to be accepted (registered)
//   row_o           out  CNT_W    row of the next pixel to be accepted (registered)
//   window_valid_o  out  1        window complete, registered, 1 cycle after the accepting edge
//   busy_o          out  1        high in FILL and RUN
//   frame_done_o    out  1        one-cycle pulse after the last pixel of the frame
// BEHAVIOUR
//   Reset (rst=0, any time, including mid-frame):
//     - state returns to IDLE
//     - col_o, row_o, window_valid_o, busy_o and frame_done_o clear to 0
//     - lb_wr_en and lb_rd_en drop to 0 immediately
//   accept = done_i & (state==FILL | state==RUN); done_i is ignored in IDLE and DONE.
//   Enables, for buffer index k:
//     - lb_wr_en[k] = accept & (k==0 | row_o>=k)
//     - lb_rd_en[k] = accept & (row_o>=k+1)
//   Counters, on accept:
//     - col_o increments; at col_o==WIDTH-1 it wraps to 0 and row_o increments
//     - row_o never exceeds HEIGHT-1
//     - with done_i low, all state holds (stalls of any length are legal)
//   window_valid_o registers: accept & row_o>=KSIZE-1 & col_o>=KSIZE-1.
//     - Valid windows per frame = (HEIGHT-KSIZE+1)*(WIDTH-KSIZE+1).
//   FSM states:
//     - IDLE -> FILL  on start_i
//     - FILL -> RUN   on accept of pixel (row KSIZE-2, col WIDTH-1), i.e. all buffers primed
//     - RUN  -> DONE  on accept of pixel (HEIGHT-1, WIDTH-1); counters clear to 0 on that edge
//     - DONE -> IDLE  unconditionally after 1 cycle; frame_done_o=1 only while in DONE
//   Boundary and corner cases:
//     - start_i while in FILL, RUN or DONE is ignored; no queuing
//     - start_i in the cycle DONE->IDLE is ignored
//     - start_i held high from that IDLE cycle starts the next frame
//     - KSIZE=2: FILL exits after row 0; only buffer 0 exists
// STRUCTURE
//   Shared header prep_defs.vh holds:
//     - FSM state encodings: IDLE=2'd0, FILL=2'd1, RUN=2'd2, DONE=2'd3
//     - default WIDTH/HEIGHT/KSIZE, shared with Line_buffer and the window/filter stages
//   Sub-module pixel_position_counter (params WIDTH, HEIGHT, CNT_W):
//     - inputs: clk, rst, clr, inc
//     - outputs: col, row, last_col, last_pix
//   The top level holds the FSM, the enable decode and the window_valid register.
// TESTING  (WIDTH=5, HEIGHT=4, KSIZE=3 unless noted)
//   1. Pull rst low after 7 pixels -> all outputs 0 the same cycle; next start_i begins at (0,0).
//   2. start_i, then done_i continuously high:
//      - lb_wr_en[0] high from pixel 0
//      - lb_rd_en[0] and lb_wr_en[1] first high at pixel 5
//      - lb_rd_en[1] first high at pixel 10
//      - FILL->RUN after pixel 9
//   3. Continuous frame -> window_valid_o high after pixels 12,13,14,17,18,19 only (6 pulses).
//   4. done_i pattern 1,0,0,1,... -> counters and enables advance only on high cycles; same 6 valids.
//   5. Frame end and back-to-back start:
//      - pixel 19 accepted -> frame_done_o pulses once next cycle, busy_o=0
//      - further done_i produces no enables
//      - start_i held high from the following IDLE cycle begins the next frame
//   6. start_i pulsed during RUN -> no effect on counters.
//      KSIZE=2: only buffer 0 is driven; 12 valids per frame.

Source files
------------

// File: rtl/line_window_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// line_window_sequencer_pkg
//   Shared definitions for the preparation stage.
//   - FSM state encodings (IDLE/FILL/RUN/DONE)
//   - Default frame geometry and window size. The line buffers and the
//     window/filter stages use the same defaults.
// ---------------------------------------------------------------------------
package line_window_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 17;
  localparam int DEF_HEIGHT = 17;
  localparam int DEF_KSIZE  = 3;
  localparam int DEF_CNT_W  = 10;

endpackage

// File: rtl/line_window_sequencer_if.sv
// ---------------------------------------------------------------------------
// line_window_sequencer_if
//   Bundles the frame-control handshake and the line-buffer control outputs
//   of the sequencer.
//   master : upstream / frame controller side (drives start_i, done_i)
//   slave  : the sequencer itself
//   Signals:
//     start_i         frame start pulse
//     done_i          pixel valid strobe, one pixel per high cycle
//     lb_wr_en        per-buffer write enable, KSIZE-1 bits
//     lb_rd_en        per-buffer read enable, KSIZE-1 bits
//     col_o / row_o   position of the next pixel to be accepted
//     window_valid_o  a full KSIZE x KSIZE window is available
//     busy_o          frame in progress
//     frame_done_o    one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
interface line_window_sequencer_if
  import line_window_sequencer_pkg::*;
#(
  parameter int KSIZE = DEF_KSIZE,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start_i;
  logic             done_i;
  logic [KSIZE-2:0] lb_wr_en;
  logic [KSIZE-2:0] lb_rd_en;
  logic [CNT_W-1:0] col_o;
  logic [CNT_W-1:0] row_o;
  logic             window_valid_o;
  logic             busy_o;
  logic             frame_done_o;

  modport master (
    output start_i, done_i,
    input  lb_wr_en, lb_rd_en, col_o, row_o, window_valid_o, busy_o, frame_done_o
  );

  modport slave (
    input  start_i, done_i,
    output lb_wr_en, lb_rd_en, col_o, row_o, window_valid_o, busy_o, frame_done_o
  );

endinterface

// File: rtl/line_window_sequencer_pixel_position_counter.sv
// ---------------------------------------------------------------------------
// line_window_sequencer_pixel_position_counter
//   Row/column position of the next pixel to be accepted.
//   Ports:
//     clk       clock, rising edge
//     rst       asynchronous active-low reset
//     clr       synchronous clear to (0,0); takes priority over inc
//     inc       advance one pixel; wraps the column at WIDTH-1 and bumps the row
//     col, row  current position
//     last_col  col == WIDTH-1
//     last_pix  position is (HEIGHT-1, WIDTH-1)
// ---------------------------------------------------------------------------
module line_window_sequencer_pixel_position_counter #(
  parameter int WIDTH  = 17,
  parameter int HEIGHT = 17,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last_col,
  output logic             last_pix
);

  logic [CNT_W-1:0] col_reg;
  logic [CNT_W-1:0] row_reg;
  logic             last_row;

  assign last_col = (col_reg == CNT_W'(WIDTH - 1));
  assign last_row = (row_reg == CNT_W'(HEIGHT - 1));
  assign last_pix = last_col & last_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (clr) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (inc) begin
      if (last_col) begin
        col_reg <= '0;
        // The row saturates so that a missing clear can never push it
        // beyond the frame.
        if (!last_row) begin
          row_reg <= row_reg + 1'b1;
        end
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign col = col_reg;
  assign row = row_reg;

endmodule

// File: rtl/line_window_sequencer.sv
// ---------------------------------------------------------------------------
// line_window_sequencer
//   Frame-level sequencer for the preparation stage. Drives a chain of
//   KSIZE-1 line buffers (buffer 0 takes raw pixels, buffer k takes the
//   output of buffer k-1), tracks the position of every accepted pixel and
//   flags when a complete KSIZE x KSIZE window is available downstream.
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-low reset
//     bus   line_window_sequencer_if.slave (start/strobe in, enables and
//           status out)
// ---------------------------------------------------------------------------
module line_window_sequencer
  import line_window_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int KSIZE  = DEF_KSIZE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  line_window_sequencer_if.slave  bus
);

  state_t           state_reg;
  logic             busy_reg;
  logic             frame_done_reg;
  logic             window_valid_reg;

  logic             accept;
  logic             primed;
  logic             window_hit;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             last_col;
  logic             last_pix;

  // Pixels are only taken while a frame is in flight.
  assign accept = bus.done_i & ((state_reg == FILL) | (state_reg == RUN));

  line_window_sequencer_pixel_position_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CNT_W  (CNT_W)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept & last_pix),
    .inc      (accept),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // Buffer k starts writing once row k is reached (its input, buffer k-1,
  // holds a full line), and starts reading once it holds a full line itself.
  for (genvar gi = 0; gi < KSIZE - 1; gi++) begin : g_lb_en
    if (gi == 0) begin : g_first
      assign bus.lb_wr_en[gi] = accept;
    end else begin : g_chain
      assign bus.lb_wr_en[gi] = accept & (row >= CNT_W'(gi));
    end
    assign bus.lb_rd_en[gi] = accept & (row >= CNT_W'(gi + 1));
  end

  // All buffers are primed once the last pixel of row KSIZE-2 goes in.
  assign primed     = accept & last_col & (row == CNT_W'(KSIZE - 2));
  assign window_hit = accept & (row >= CNT_W'(KSIZE - 1)) & (col >= CNT_W'(KSIZE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            state_reg <= FILL;
            busy_reg  <= 1'b1;
          end
        end
        FILL: begin
          if (primed) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (accept & last_pix) begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        DONE: begin
          // start_i is deliberately not looked at here.
          state_reg      <= IDLE;
          frame_done_reg <= 1'b0;
        end
        default: begin
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
          frame_done_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_valid_reg <= 1'b0;
    end else begin
      window_valid_reg <= window_hit;
    end
  end

  assign bus.col_o          = col;
  assign bus.row_o          = row;
  assign bus.busy_o         = busy_reg;
  assign bus.frame_done_o   = frame_done_reg;
  assign bus.window_valid_o = window_valid_reg;

endmodule
